// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit: sequencing FSM, result staging and HI/LO registers.
// Optional feature: define MDU_MADD_EN to enable mdop 6 (madd); otherwise mdop 6 is reserved.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] numa,
    input  logic [31:0] numb,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_RSVD  = 3'd7
    } mdop_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES);

    state_e      state, state_next;
    logic [4:0]  counter, counter_next;
    logic        launch, move_hi, move_lo, commit;
    logic        op_launch, op_div;

    // Staged result, captured when the operation is accepted.
    logic [31:0] stage_hi, stage_lo;
    logic        stage_wr;
`ifdef MDU_MADD_EN
    logic        stage_madd;
`endif

    logic [31:0] res_hi, res_lo;
    logic        res_wr;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, s_den, sq_mag, sr_mag, sq, sr;
    logic [31:0] u_den, uq, ur;

    // ------------------------------------------------------------------
    // Operation decode
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        op_launch = 1'b0;
        op_div    = 1'b0;
        case (mdop)
            OP_MULT, OP_MULTU: op_launch = 1'b1;
            OP_DIV, OP_DIVU: begin
                op_launch = 1'b1;
                op_div    = 1'b1;
            end
`ifdef MDU_MADD_EN
            OP_MADD: op_launch = 1'b1;
`endif
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Arithmetic, evaluated on the operands present at the start pulse
    // ------------------------------------------------------------------
    assign prod_s = $signed(numa) * $signed(numb);
    assign prod_u = {32'd0, numa} * {32'd0, numb};

    // Signed divide via magnitudes avoids the 0x80000000 / -1 overflow corner.
    assign a_mag  = numa[31] ? -numa : numa;
    assign b_mag  = numb[31] ? -numb : numb;
    assign s_den  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign sq_mag = a_mag / s_den;
    assign sr_mag = a_mag % s_den;
    assign sq     = (numa[31] ^ numb[31]) ? -sq_mag : sq_mag;
    assign sr     = numa[31] ? -sr_mag : sr_mag;

    assign u_den  = (numb == 32'd0) ? 32'd1 : numb;
    assign uq     = numa / u_den;
    assign ur     = numa % u_den;

    always_comb begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        res_wr = 1'b1;
        case (mdop)
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                res_hi = sr;
                res_lo = sq;
                res_wr = (numb != 32'd0);
            end
            OP_DIVU: begin
                res_hi = ur;
                res_lo = uq;
                res_wr = (numb != 32'd0);
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            counter <= 5'd0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
        end
    end

    always_comb begin
        state_next   = state;
        counter_next = counter;
        launch       = 1'b0;
        move_hi      = 1'b0;
        move_lo      = 1'b0;
        commit       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op_launch) begin
                        launch       = 1'b1;
                        state_next   = RUN;
                        counter_next = op_div ? DIV_LOAD : MULT_LOAD;
                    end else begin
                        move_hi = (mdop == OP_MTHI);
                        move_lo = (mdop == OP_MTLO);
                    end
                end
            end
            RUN: begin
                // Requests arriving here are dropped; decode stalls them upstream.
                if (counter <= 5'd1) begin
                    commit       = 1'b1;
                    counter_next = 5'd0;
                    state_next   = IDLE;
                end else begin
                    counter_next = counter - 5'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    // ------------------------------------------------------------------
    // Staging registers
    // ------------------------------------------------------------------
    // NOTE: staging holds data only; reset returns the FSM to IDLE so a stale value is never committed.
    always_ff @(posedge clk) begin
        if (launch) begin
            stage_hi <= res_hi;
            stage_lo <= res_lo;
            stage_wr <= res_wr;
`ifdef MDU_MADD_EN
            stage_madd <= (mdop == OP_MADD);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Architectural HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (commit) begin
`ifdef MDU_MADD_EN
            if (stage_madd) begin
                {hi, lo} <= {hi, lo} + {stage_hi, stage_lo};
            end else if (stage_wr) begin
                hi <= stage_hi;
                lo <= stage_lo;
            end
`else
            if (stage_wr) begin
                hi <= stage_hi;
                lo <= stage_lo;
            end
`endif
        end else begin
            if (move_hi) hi <= numa;
            if (move_lo) lo <= numa;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed test-plan steps plus random operations
// checked against an arithmetic reference model of HI/LO and busy latency.
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    typedef longint unsigned u64_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] numa;
    logic [31:0] numb;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_ctrl #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .mdop (mdop),
        .numa (numa),
        .numb (numb),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total_cnt = total_cnt + 1;
        assert (obs === want) pass_cnt = pass_cnt + 1;
        else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // Expected busy length of an accepted request issued while idle.
    function automatic int op_latency(input logic [2:0] op);
        case (op)
            3'd0, 3'd1: return MULT_N;
            3'd2, 3'd3: return DIV_N;
`ifdef MDU_MADD_EN
            3'd6:       return MULT_N;
`endif
            default:    return 0;
        endcase
    endfunction

    // Architectural effect of one operation on HI/LO.
    function automatic void model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int     sa, sb;
        longint p;
        u64_t   pu;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd0: begin
                p = longint'(sa) * longint'(sb);
                {m_hi, m_lo} = p;
            end
            3'd1: begin
                pu = u64_t'(a) * u64_t'(b);
                {m_hi, m_lo} = pu;
            end
            3'd2: begin
                if (b != 32'd0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        m_lo = 32'h8000_0000;
                        m_hi = 32'd0;
                    end else begin
                        m_lo = 32'(sa / sb);
                        m_hi = 32'(sa % sb);
                    end
                end
            end
            3'd3: begin
                if (b != 32'd0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
`ifdef MDU_MADD_EN
            3'd6: begin
                p = longint'({m_hi, m_lo}) + longint'(sa) * longint'(sb);
                {m_hi, m_lo} = p;
            end
`endif
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one request from idle, measure busy, compare HI/LO afterwards.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] old_hi, old_lo;
        logic        hold_ok;
        int          n, exp_n;
        old_hi  = hi;
        old_lo  = lo;
        hold_ok = 1'b1;
        exp_n   = op_latency(op);
        @(negedge clk);
        start = 1'b1;
        mdop  = op;
        numa  = a;
        numb  = b;
        @(negedge clk);
        start = 1'b0;
        numa  = $urandom;
        numb  = $urandom;
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            if (hi !== old_hi || lo !== old_lo) hold_ok = 1'b0;
            n++;
            @(negedge clk);
        end
        model_apply(op, a, b);
        check({tag, " busy_cycles"}, 32'(n), 32'(exp_n));
        if (exp_n > 0) check({tag, " hold"}, 32'(hold_ok), 32'd1);
        check({tag, " hi"}, hi, m_hi);
        check({tag, " lo"}, lo, m_lo);
    endtask

    initial begin
        int          n;
        logic        saw_busy;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        reset = 1'b1;
        start = 1'b0;
        mdop  = 3'd0;
        numa  = 32'd0;
        numb  = 32'd0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        reset = 1'b0;

        // Directed test-plan steps
        do_op(3'd0, 32'hFFFF_FFFD, 32'd5, "mult -3*5");
        do_op(3'd1, 32'hFFFF_FFFF, 32'd2, "multu ffffffff*2");
        do_op(3'd4, 32'h0000_1234, 32'd0, "mthi 1234");
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div -7/2");
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div min/-1");
        do_op(3'd4, 32'h0000_00AA, 32'd0, "mthi aa");
        do_op(3'd5, 32'h0000_00BB, 32'd0, "mtlo bb");
        do_op(3'd3, 32'd100, 32'd0, "divu 100/0");
        do_op(3'd7, 32'h1111_1111, 32'h2222_2222, "reserved op7");

        // Requests while busy must be dropped.
        @(negedge clk);
        start = 1'b1;
        mdop  = 3'd1;
        numa  = 32'd3;
        numb  = 32'd4;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            if (n == 2) begin
                start = 1'b1;
                mdop  = 3'd5;
                numa  = 32'h55;
            end else if (n == 3) begin
                start = 1'b1;
                mdop  = 3'd2;
                numa  = 32'd7;
                numb  = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        model_apply(3'd1, 32'd3, 32'd4);
        check("busy-drop busy_cycles", 32'(n), 32'(MULT_N));
        check("busy-drop hi", hi, m_hi);
        check("busy-drop lo", lo, m_lo);
        @(negedge clk);
        check("busy-drop no relaunch", 32'(busy), 32'd0);

        // Reset in the middle of a divide.
        do_op(3'd4, 32'h77, 32'd0, "mthi 77");
        @(negedge clk);
        start = 1'b1;
        mdop  = 3'd2;
        numa  = 32'd100;
        numb  = 32'd7;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 3) begin
            n++;
            if (n < 3) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort hi", hi, m_hi);
        check("abort lo", lo, m_lo);
        saw_busy = 1'b0;
        repeat (DIV_N + 2) begin
            @(negedge clk);
            if (busy !== 1'b0) saw_busy = 1'b1;
        end
        check("abort no late busy", 32'(saw_busy), 32'd0);
        check("abort no late hi", hi, m_hi);
        check("abort no late lo", lo, m_lo);

        // madd (or ignored op 6 when the feature is absent)
        do_op(3'd5, 32'hFFFF_FFFF, 32'd0, "mtlo ffffffff");
        do_op(3'd6, 32'd1, 32'd1, "op6 1*1");

        // Random operations
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick_val();
            rb  = pick_val();
            do_op(rop, ra, rb, $sformatf("rand%0d op%0d", i, rop));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
